// File: rtl/alu_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : alu_multiciclo
// Description : Execute-stage ALU with a valid/ready handshake on both sides.
//               Single-cycle ops: logic, add/sub, shifts, set-less-than,
//               address calculation (word and byte), ori/slli, and branch
//               compare (bne/beq). With ALU_MULDIV_EN defined it also does
//               iterative mul/divu/remu in WIDTH cycles (BUSY state).
//               Without ALU_MULDIV_EN those codes are unsupported (op_err).
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready     request handshake
//               alusrc, alucontrol    operand B source, operation select
//               ler_dados1/2          operands A/B
//               imediato, negativo    immediate magnitude and its sign
//               branch                instruction is a branch
//               out_valid/out_ready   result handshake
//               aluresult2            result
//               aluresult1            branch-condition flag
//               pcsrc                 flag & latched branch & out_valid
//               op_err                unsupported alucontrol/alusrc
// Config      : `define ALU_MULDIV_EN enables iterative mul/divu/remu
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alusrc,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] ler_dados1,
    input  logic [WIDTH-1:0] ler_dados2,
    input  logic [IMM_W-1:0] imediato,
    input  logic             negativo,
    input  logic             branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluresult2,
    output logic             aluresult1,
    output logic             pcsrc,
    output logic             op_err
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
`ifdef ALU_MULDIV_EN
        , S_BUSY = 2'd1
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             err_q, err_d;
    logic             branch_q, branch_d;

    // Combinational decode of the request presented on the inputs
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_imm;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_flag;
    logic             w_err;

`ifdef ALU_MULDIV_EN
    localparam int         CNT_W  = $clog2(WIDTH + 1);
    localparam logic [1:0] MD_MUL = 2'd0;
    localparam logic [1:0] MD_DIV = 2'd1;
    localparam logic [1:0] MD_REM = 2'd2;

    logic             w_md;
    logic [1:0]       w_md_op;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mdop_q, mdop_d;
    // Multiply: acc = partial product, opa = multiplier (shifts right),
    //           opb = multiplicand (shifts left).
    // Divide:   acc = partial remainder, opa = dividend shifting out its MSB
    //           while quotient bits shift in at the LSB, opb = divisor.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   w_rem_sh;
`endif

    assign w_a   = ler_dados1;
    assign w_imm = WIDTH'(imediato);
    assign w_b   = alusrc ? w_imm : ler_dados2;
    assign w_sh  = w_b[SHW-1:0];

    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        w_err  = 1'b0;
`ifdef ALU_MULDIV_EN
        w_md    = 1'b0;
        w_md_op = MD_MUL;
`endif
        if (!alusrc) begin
            case (alucontrol)
                4'b0000: w_res = w_a & w_b;
                4'b0001: w_res = w_a | w_b;
                4'b0010: w_res = w_a + w_b;
                4'b0110: w_res = w_a - w_b;
                4'b0100: w_res = w_a ^ w_b;
                4'b0101: w_res = WIDTH'($signed(w_a) >>> w_sh);
                4'b1000: w_res = w_a >> w_sh;
                4'b1010: w_res = w_a << w_sh;
                4'b0111: w_res = WIDTH'($signed(w_a) < $signed(w_b));
`ifdef ALU_MULDIV_EN
                4'b1011: begin w_md = 1'b1; w_md_op = MD_MUL; end
                4'b1101: begin w_md = 1'b1; w_md_op = MD_DIV; end
                4'b1110: begin w_md = 1'b1; w_md_op = MD_REM; end
`endif
                default: w_err = 1'b1;
            endcase
        end else begin
            case (alucontrol)
                // Word-indexed memory: immediate counts bytes, scaled to words
                4'b0010: w_res = negativo ? (w_a - (w_imm >> 2)) : (w_a + (w_imm >> 2));
                4'b0011,
                4'b1100: w_res = negativo ? (w_a - w_imm) : (w_a + w_imm);
                4'b1001: w_res = w_a | w_imm;
                4'b1010: w_res = w_a << w_sh;
                // Branch compares always use the register operand
                4'b0110: begin
                    w_res  = w_a - ler_dados2;
                    w_flag = (w_a != ler_dados2);
                end
                4'b1111: begin
                    w_res  = w_a - ler_dados2;
                    w_flag = (w_a == ler_dados2);
                end
                default: w_err = 1'b1;
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    assign w_rem_sh = {1'b0, acc_q[WIDTH-1:0], opa_q[WIDTH-1]} >> 0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_d   = flag_q;
        err_d    = err_q;
        branch_d = branch_q;
`ifdef ALU_MULDIV_EN
        cnt_d  = cnt_q;
        mdop_d = mdop_q;
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    branch_d = branch;
`ifdef ALU_MULDIV_EN
                    if (w_md) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(WIDTH);
                        mdop_d  = w_md_op;
                        acc_d   = '0;
                        opa_d   = w_a;
                        opb_d   = w_b;
                        flag_d  = 1'b0;
                        err_d   = 1'b0;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        result_d = w_res;
                        flag_d   = w_flag;
                        err_d    = w_err;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = (mdop_q == MD_DIV) ? opa_q : acc_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (mdop_q == MD_MUL) begin
                        acc_d = acc_q + (opa_q[0] ? opb_q : '0);
                        opa_d = opa_q >> 1;
                        opb_d = opb_q << 1;
                    end else if (w_rem_sh >= {1'b0, opb_q}) begin
                        // Restoring step; a zero divisor always subtracts,
                        // giving an all-ones quotient and remainder = A.
                        acc_d = WIDTH'(w_rem_sh - {1'b0, opb_q});
                        opa_d = {opa_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = w_rem_sh[WIDTH-1:0];
                        opa_d = {opa_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            branch_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q  <= '0;
            mdop_q <= MD_MUL;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            branch_q <= branch_d;
`ifdef ALU_MULDIV_EN
            cnt_q  <= cnt_d;
            mdop_q <= mdop_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
`endif
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign aluresult2 = result_q;
    assign aluresult1 = flag_q;
    assign op_err     = err_q;
    assign pcsrc      = flag_q & branch_q & out_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multiciclo
// Description : Scoreboard bench for alu_multiciclo. The driver pushes the
//               expected response when a request is accepted; an independent
//               monitor compares whenever out_valid is high and pops on the
//               completing handshake. Directed cases plus random requests
//               checked against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multiciclo;

    localparam int W  = 32;
    localparam int IW = 12;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          alusrc = 1'b0;
    logic [3:0]    alucontrol = 4'd0;
    logic [W-1:0]  ler_dados1 = '0;
    logic [W-1:0]  ler_dados2 = '0;
    logic [IW-1:0] imediato = '0;
    logic          negativo = 1'b0;
    logic          branch = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  aluresult2;
    logic          aluresult1;
    logic          pcsrc;
    logic          op_err;

    alu_multiciclo #(.WIDTH(W), .IMM_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alusrc     (alusrc),
        .alucontrol (alucontrol),
        .ler_dados1 (ler_dados1),
        .ler_dados2 (ler_dados2),
        .imediato   (imediato),
        .negativo   (negativo),
        .branch     (branch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluresult2 (aluresult2),
        .aluresult1 (aluresult1),
        .pcsrc      (pcsrc),
        .op_err     (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         flag;
        logic         err;
        logic         pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   hold_cycles = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Reference model: returns the expected response and the number of
    // sampled cycles with out_valid low between accept and result.
    function automatic exp_t model(input bit src, input bit [3:0] ctl,
                                   input bit [W-1:0] a, input bit [W-1:0] b,
                                   input bit [IW-1:0] imm, input bit neg,
                                   input bit br, output int idle);
        exp_t e;
        bit [W-1:0] iv;
        int unsigned sh;
        iv     = W'(imm);
        e.res  = '0;
        e.flag = 1'b0;
        e.err  = 1'b0;
        idle   = 0;
        if (!src) begin
            sh = b % W;
            case (ctl)
                4'd0:  e.res = a & b;
                4'd1:  e.res = a | b;
                4'd2:  e.res = a + b;
                4'd6:  e.res = a - b;
                4'd4:  e.res = a ^ b;
                4'd5:  e.res = W'($signed(a) >>> sh);
                4'd8:  e.res = a >> sh;
                4'd10: e.res = a << sh;
                4'd7:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                4'd11: if (MD) e.res = W'(longint'(a) * longint'(b)); else e.err = 1'b1;
                4'd13: if (MD) e.res = (b == 0) ? {W{1'b1}} : a / b; else e.err = 1'b1;
                4'd14: if (MD) e.res = (b == 0) ? a : a % b; else e.err = 1'b1;
                default: e.err = 1'b1;
            endcase
            if (MD && (ctl == 4'd11 || ctl == 4'd13 || ctl == 4'd14)) idle = W + 1;
        end else begin
            case (ctl)
                4'd2:  e.res = neg ? a - iv / 4 : a + iv / 4;
                4'd3,
                4'd12: e.res = neg ? a - iv : a + iv;
                4'd9:  e.res = a | iv;
                4'd10: e.res = a << (iv % W);
                4'd6:  begin e.res = a - b; e.flag = (a != b); end
                4'd15: begin e.res = a - b; e.flag = (a == b); end
                default: e.err = 1'b1;
            endcase
        end
        e.pc = e.flag & br;
        return e;
    endfunction

    // Issue one request with the given expectation, then keep toggling
    // in_valid with junk until the block is ready again (junk must be ignored).
    task automatic drive(input bit src, input bit [3:0] ctl, input bit [W-1:0] a,
                         input bit [W-1:0] b, input bit [IW-1:0] imm, input bit neg,
                         input bit br, input exp_t e, input int idle_req);
        int  k;
        int  idle;
        bit  seen;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: got 0, required 1");
            return;
        end
        alusrc     = src;
        alucontrol = ctl;
        ler_dados1 = a;
        ler_dados2 = b;
        imediato   = imm;
        negativo   = neg;
        branch     = br;
        in_valid   = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        idle = 0;
        seen = 1'b0;
        k    = 0;
        do begin
            @(negedge clk);
            k++;
            if (!seen) begin
                if (out_valid) seen = 1'b1;
                else idle++;
            end
            if (!in_ready) begin
                in_valid   = 1'($urandom);
                alusrc     = 1'($urandom);
                alucontrol = 4'($urandom);
                ler_dados1 = $urandom;
                ler_dados2 = $urandom;
                imediato   = IW'($urandom);
                branch     = 1'($urandom);
            end
        end while (!in_ready && k < 300);
        in_valid = 1'b0;
        chk("latency", W'(idle), W'(idle_req));
    endtask

    task automatic dir(input bit src, input bit [3:0] ctl, input bit [W-1:0] a,
                       input bit [W-1:0] b, input bit [IW-1:0] imm, input bit neg,
                       input bit br, input bit [W-1:0] res, input bit flag, input bit err);
        exp_t e;
        exp_t m;
        int   idle;
        m      = model(src, ctl, a, b, imm, neg, br, idle);
        e.res  = res;
        e.flag = flag;
        e.err  = err;
        e.pc   = flag & br;
        drive(src, ctl, a, b, imm, neg, br, e, idle);
    endtask

    task automatic rnd();
        exp_t e;
        int   idle;
        bit   src;
        bit [3:0] ctl;
        bit [W-1:0] a, b;
        bit [IW-1:0] imm;
        bit neg, br;
        src = 1'($urandom);
        ctl = 4'($urandom);
        a   = $urandom;
        b   = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
        if ($urandom_range(0, 3) == 0) b = a;
        if ($urandom_range(0, 3) == 0) b = b % 64;
        imm = IW'($urandom);
        neg = 1'($urandom);
        br  = 1'($urandom);
        e = model(src, ctl, a, b, imm, neg, br, idle);
        drive(src, ctl, a, b, imm, neg, br, e, idle);
    endtask

    // Monitor: owns out_ready, compares every cycle a result is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && hold_cycles > 0) begin
                    out_ready   = 1'b0;
                    hold_cycles = hold_cycles - 1;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_valid) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_result: got res=%h with empty queue, required none", aluresult2);
                    end else begin
                        e = sb_q[0];
                        if (aluresult2 !== e.res || aluresult1 !== e.flag ||
                            op_err !== e.err || pcsrc !== e.pc || in_ready !== 1'b0) begin
                            n_errors++;
                            $display("FAIL result: got res=%h flag=%b err=%b pcsrc=%b in_ready=%b, required res=%h flag=%b err=%b pcsrc=%b in_ready=0",
                                     aluresult2, aluresult1, op_err, pcsrc, in_ready,
                                     e.res, e.flag, e.err, e.pc);
                        end
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end else begin
                    chk("pcsrc_outside_done", W'(pcsrc), '0);
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_result", aluresult2, '0);
        chk("rst_flag", W'(aluresult1), '0);
        chk("rst_pcsrc", W'(pcsrc), '0);
        chk("rst_op_err", W'(op_err), '0);
    endtask

    initial begin
        exp_t e;
        int   idle;
        int   k;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        dir(1, 4'b0011, 100, 0, 5, 1, 0, 95, 0, 0);
        dir(1, 4'b0010, 100, 0, 8, 0, 0, 102, 0, 0);
        dir(1, 4'b1001, 32'hF0, 0, 12'h0F, 0, 0, 32'hFF, 0, 0);
        dir(1, 4'b1111, 32'h1234, 32'h1234, 0, 0, 1, 0, 1, 0);
        dir(1, 4'b0110, 32'h1234, 32'h1234, 0, 0, 1, 0, 0, 0);
        dir(1, 4'b0110, 10, 3, 0, 0, 1, 7, 1, 0);
        dir(0, 4'b0101, 32'h8000_0000, 4, 0, 0, 0, 32'hF800_0000, 0, 0);
        dir(0, 4'b1000, 32'h8000_0000, 4, 0, 0, 0, 32'h0800_0000, 0, 0);
        dir(0, 4'b0111, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 0);
        dir(0, 4'b1010, 1, 33, 0, 0, 0, 2, 0, 0);
        dir(0, 4'b0010, 3, 4, 0, 0, 1, 7, 0, 0);
        dir(1, 4'b1010, 3, 0, 4, 0, 0, 32'h30, 0, 0);
        dir(1, 4'b1100, 32'h100, 0, 1, 1, 0, 32'hFF, 0, 0);
        dir(1, 4'b0000, 5, 5, 1, 0, 1, 0, 0, 1);
        dir(0, 4'b1111, 5, 5, 0, 0, 0, 0, 0, 1);
        dir(0, 4'b1011, 32'hFFFF_FFFF, 2, 0, 0, 0, MD ? 32'hFFFF_FFFE : 32'h0, 0, !MD);
        dir(0, 4'b1101, 100, 7, 0, 0, 0, MD ? 32'd14 : 32'd0, 0, !MD);
        dir(0, 4'b1110, 100, 7, 0, 0, 0, MD ? 32'd2 : 32'd0, 0, !MD);
        dir(0, 4'b1101, 5, 0, 0, 0, 0, MD ? 32'hFFFF_FFFF : 32'd0, 0, !MD);
        dir(0, 4'b1110, 5, 0, 0, 0, 0, MD ? 32'd5 : 32'd0, 0, !MD);

        // Backpressure: result held for 5 cycles while junk requests arrive
        hold_cycles = 5;
        dir(0, 4'b0100, 32'hA5A5_0000, 32'h0000_5A5A, 0, 0, 0, 32'hA5A5_5A5A, 0, 0);
        hold_cycles = 0;

        // Random requests against the reference model
        for (int i = 0; i < 150; i++) rnd();

        // Reset in the middle of a mul (BUSY with mul/div, held DONE without)
        k = 0;
        while (!in_ready && k < 300) begin @(negedge clk); k++; end
        hold_cycles = 1000;
        e = model(0, 4'b1011, 7, 6, 0, 0, 0, idle);
        alusrc = 0; alucontrol = 4'b1011; ler_dados1 = 7; ler_dados2 = 6;
        imediato = '0; negativo = 0; branch = 0; in_valid = 1;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        sb_q.delete();
        hold_cycles = 0;
        @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);
        dir(0, 4'b0010, 3, 4, 0, 0, 0, 7, 0, 0);

        // Drain and make sure nothing is left outstanding
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
        chk("queue_drained", W'(sb_q.size()), '0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, handshaked successor to the datapath ALU. It covers the same register/immediate operation set: logic, add/sub, shifts, word-address calculation, and branch compare. It adds set-less-than, logical right shift, and optional iterative multiply/divide. It sits in the execute stage between the register file/immediate generator and the write-back/PC-select logic, and replaces state-number gating with a valid/ready handshake so the control FSM can stall on multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width (≥8, power of two)
- IMM_W, 12, immediate magnitude width (≤ WIDTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- alusrc  in  1  0 = register operand B, 1 = immediate
- alucontrol  in  4  operation select
- ler_dados1  in  WIDTH  operand A
- ler_dados2  in  WIDTH  operand B
- imediato  in  IMM_W  immediate magnitude, unsigned
- negativo  in  1  immediate is negative (subtract magnitude)
- branch  in  1  instruction is a branch
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- aluresult2  out  WIDTH  result
- aluresult1  out  1  branch-condition flag
- pcsrc  out  1  aluresult1 & latched branch & out_valid
- op_err  out  1  unsupported alucontrol/alusrc combination

## Operation
- Operands, alusrc, alucontrol, negativo and branch are captured on the accept edge (in_valid & in_ready); inputs are don't-care afterwards.
- Shift amount = low log2(WIDTH) bits of B or immediate; imm zero-extended to WIDTH.
- alusrc=0: 0000 and, 0001 or, 0010 add, 0110 sub, 0100 xor, 0101 sra (arithmetic), 1000 srl, 1010 sll, 0111 slt (signed, result 0/1), 1011 mul (low WIDTH bits), 1101 divu, 1110 remu.
- alusrc=1: 0010 address = A ± (imm >> 2) (word-indexed memory); 0011 addi = A ± imm; 1100 byte address = A ± imm; 1001 ori = A | imm; 1010 slli; 0110 bne: result A−B, flag = (A≠B); 1111 beq: result A−B, flag = (A=B).
- Flag is 0 for all non-branch ops. Arithmetic wraps modulo 2^WIDTH.
- divu by zero: quotient all ones; remu by zero: remainder = A.
- Unsupported code: result 0, flag 0, op_err 1, latency 1.
- FSM: IDLE → (accept, single-cycle op) → DONE; IDLE → (accept, mul/div/rem) → BUSY; BUSY, WIDTH cycles of shift-add / restoring division with a down-counter → DONE; DONE → (out_ready) → IDLE.
- in_ready = 1 only in IDLE; out_valid = 1 only in DONE. Result/flag/op_err are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, aluresult2 0, aluresult1 0, pcsrc 0, op_err 0, counter 0.
- Single-cycle ops: accept at edge N, out_valid high after edge N (latency 1).
- mul/div/rem: accept at N, out_valid high after edge N+WIDTH+1.
- Handshake completes on the edge with out_valid & out_ready. in_ready rises the following cycle; there is no same-cycle back-to-back accept. Throughput is 1 op per 2 cycles minimum.
- in_valid while not in_ready: ignored, not queued.
- rst_n low at any point, including mid-BUSY: immediate abort to reset values; partial result discarded.
- pcsrc is combinational from registered state; it is never high outside DONE.

## Configuration
- ALU_MULDIV_EN defined: mul/divu/remu are implemented as iterative WIDTH-cycle operations with the BUSY state.
- Not defined: the BUSY state, counter and mul/div datapath are omitted; codes 1011/1101/1110 are treated as unsupported (result 0, op_err 1, latency 1).

## Test plan
- Reset mid-BUSY during mul 7×6: assert rst_n=0 at cycle 10 → out_valid 0, result 0, in_ready 1 immediately; next accepted add 3+4 → 7 after 1 cycle.
- alusrc=1, 0011, A=100, imm=5, negativo=1 → 95; 0010, A=100, imm=8 → 102; 1001, A=0xF0, imm=0x0F → 0xFF.
- beq, branch=1, A=B=0x1234 → aluresult1 1, pcsrc 1, result 0; bne with the same operands → flag 0, pcsrc 0.
- sra 0x80000000 by 4 → 0xF8000000; srl → 0x08000000; slt −1 vs 1 → 1; sll by B=33 → shift of 1.
- With ALU_MULDIV_EN: mul 0xFFFFFFFF×2 → 0xFFFFFFFE after WIDTH+1 cycles; divu 100/7 → 14, remu → 2; divu 5/0 → 0xFFFFFFFF, remu 5/0 → 5.
- Backpressure: out_ready held 0 for 5 cycles → result stable, in_ready 0, new in_valid ignored; without ALU_MULDIV_EN, 1011 → op_err 1, result 0.
